uart_tx_port: RTL and testbench
===============================

// Module: uart_tx_port
// PURPOSE
// Memory-mapped UART transmitter on the processor's MEM stage, beside data_memory. Stores from the EX/MEM
// stage to DATA_ADDR push a byte into a TX FIFO. Loads from STATUS_ADDR return FIFO/transmitter state.
// A serializer drains the FIFO onto a standard 8N1 line, giving software a byte-stream console.
// PARAMETERS
// BAUD_DIV     434            clk cycles per UART bit (50 MHz / 115200); legal range >= 2
// FIFO_DEPTH   8              TX FIFO entries; power of 2, >= 2
// DATA_ADDR    32'h1001_0024  byte-push register (write-only; reads return 0)
// STATUS_ADDR  32'h1001_0028  status register (read; write clears sticky flag)
// PORTS
// clk            in   1   system clock; all state changes on rising edge
// reset          in   1   synchronous, active-low reset
// write_enable   in   1   MEM-stage store strobe (EX/MEM MemWrite)
// read_enable    in   1   MEM-stage load strobe (EX/MEM MemRead)
// address        in   32  MEM-stage byte address (EX/MEM ALU result, untranslated)
// write_data     in   32  store data; only [7:0] used at DATA_ADDR, only [3] at STATUS_ADDR
// hit            out  1   address equals DATA_ADDR or STATUS_ADDR (combinational); selects read_data over RAM
// read_data      out  32  load data (combinational, same cycle, for MEM/WB capture)
// tx             out  1   serial line, idle high
// tx_busy        out  1   high while a frame is on the line (START/DATA/STOP)
// BEHAVIOUR
// - Reset (reset==0 at clk edge): FIFO empty, count=0, overflow=0, FSM=IDLE, baud_cnt=0, tx=1, tx_busy=0.
//   Reset mid-frame aborts the frame: tx is 1 from the next cycle. No partial frame resumes.
// - read_data: {28'b0, overflow, tx_busy, empty, full} when read_enable && address==STATUS_ADDR, else 32'b0.
// - Push: write_enable && address==DATA_ADDR. The byte is accepted if count<FIFO_DEPTH or if a pop occurs in
//   the same cycle. Otherwise the byte is dropped and overflow is set (sticky).
// - Overflow clear: write_enable && address==STATUS_ADDR && write_data[3]==1 -> overflow=0. A drop in the
//   same cycle wins, so overflow stays 1.
// - FIFO: circular, rd/wr pointers wrap modulo FIFO_DEPTH, count is $clog2(FIFO_DEPTH)+1 bits.
//   full = (count==FIFO_DEPTH); empty = (count==0).
//   Push and pop in the same cycle leave count unchanged. A push into an empty FIFO is not popped in that cycle.
// - FSM states IDLE, START, DATA, STOP. baud_cnt counts 0..BAUD_DIV-1. bit_idx is 0..7.
//   IDLE:  tx=1. If !empty: pop into shift_reg, baud_cnt=0 -> START, effective next cycle.
//   START: tx=0 for BAUD_DIV cycles -> DATA with bit_idx=0.
//   DATA:  tx=shift_reg[0], LSB first. On baud_cnt==BAUD_DIV-1: shift right, bit_idx++.
//          After bit 7 -> STOP.
//   STOP:  tx=1 for BAUD_DIV cycles. On the last cycle: if !empty, pop and go directly to START
//          (no idle gap between frames); else go to IDLE.
// - tx is driven from a register: glitch-free, with one cycle of latency from the state change.
//   Each frame is 10*BAUD_DIV cycles. The first start-bit edge appears 2 cycles after the push edge.
// - tx_busy = (state != IDLE).
// - No backpressure to the pipeline: a store completes in one cycle whatever the FIFO state.
// TESTING (BAUD_DIV=4, FIFO_DEPTH=8 unless noted)
// 1. Reset asserted 2 cycles -> tx=1, tx_busy=0, status read = 32'h2 (empty only).
// 2. Store 0x0000_0055 to DATA_ADDR -> tx low 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then high 4 cycles.
//    Total 40 cycles; tx_busy high throughout; status returns to 32'h2 afterwards.
// 3. Nine back-to-back stores while a frame is in flight (first pops immediately) -> all accepted.
//    The 10th store while full is dropped: status = 32'h9 (overflow|full, with tx_busy=1 -> 32'hD).
//    Store 32'h8 to STATUS_ADDR -> overflow=0.
// 4. Two queued bytes 0xA5, 0x3C -> STOP of the first is followed directly by START of the second,
//    no extra high cycle; 80 cycles total.
// 5. Reset mid-DATA of byte 0xFF with 3 bytes queued -> the next cycle tx=1, tx_busy=0, status 32'h2.
//    No further frames are sent.
// 6. Load from address 32'h1001_0000 -> hit=0, read_data=0. A push while full with a simultaneous pop
//    at the last STOP cycle -> accepted, overflow stays 0.

Source files
------------

// File: rtl/uart_tx_port.sv
// ---------------------------------------------------------------------------
// uart_tx_port
//
// Memory-mapped UART transmitter that sits beside data_memory in the MEM
// stage. Stores to DATA_ADDR push a byte into a small TX FIFO. Loads from
// STATUS_ADDR report the FIFO and transmitter state. A serializer drains the
// FIFO onto an 8N1 line so software gets a simple byte-stream console.
//
// Parameters
//   BAUD_DIV     clk cycles per UART bit (>= 2)
//   FIFO_DEPTH   TX FIFO entries (power of 2, >= 2)
//   DATA_ADDR    byte-push register (write-only, reads return 0)
//   STATUS_ADDR  status register (read; writing bit 3 clears overflow)
//
// Ports
//   clk           system clock, all state changes on the rising edge
//   reset         synchronous, active-low reset
//   write_enable  MEM-stage store strobe
//   read_enable   MEM-stage load strobe
//   address       MEM-stage byte address
//   write_data    store data ([7:0] at DATA_ADDR, [3] at STATUS_ADDR)
//   hit           address decodes to one of this block's registers
//   read_data     combinational load data {28'b0, overflow, tx_busy, empty, full}
//   tx            serial line, idle high, driven from a register
//   tx_busy       high while a frame is on the line
// ---------------------------------------------------------------------------
module uart_tx_port #(
  parameter int unsigned BAUD_DIV    = 434,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [31:0] DATA_ADDR   = 32'h1001_0024,
  parameter logic [31:0] STATUS_ADDR = 32'h1001_0028
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        hit,
  output logic [31:0] read_data,
  output logic        tx,
  output logic        tx_busy
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(BAUD_DIV);

  localparam logic [CNT_W-1:0]  DEPTH_VAL = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_reg;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  logic data_sel;
  logic status_sel;
  logic push_req;
  logic clear_req;
  logic push_ok;
  logic drop;
  logic pop;
  logic empty;
  logic full;
  logic baud_last;

  // Only the low byte of a store carries payload; the upper bits are
  // deliberately ignored and folded here so they are visibly accounted for.
  logic unused_bits;
  assign unused_bits = ^write_data[31:8];

  // Address decode and bus strobes. hit is purely a function of the
  // address so the MEM stage can steer its load mux in the same cycle.
  assign data_sel   = (address == DATA_ADDR);
  assign status_sel = (address == STATUS_ADDR);
  assign hit        = data_sel || status_sel;
  assign push_req   = write_enable && data_sel;
  assign clear_req  = write_enable && status_sel && write_data[3];

  // FIFO occupancy flags come straight from the registered count, which
  // is what makes a byte pushed into an empty FIFO invisible to the
  // serializer until the following cycle.
  assign empty     = (count == '0);
  assign full      = (count == DEPTH_VAL);
  assign baud_last = (baud_cnt == BAUD_LAST);
  assign tx_busy   = (state != IDLE);

  // The serializer takes a byte either when it is idle or on the very last
  // cycle of a stop bit, which is what chains frames with no idle gap.
  // A push while full still succeeds if that same cycle frees a slot.
  always_comb begin
    pop     = 1'b0;
    push_ok = 1'b0;
    drop    = 1'b0;
    if (!empty) begin
      if (state == IDLE) begin
        pop = 1'b1;
      end else if (state == STOP && baud_last) begin
        pop = 1'b1;
      end
    end
    if (push_req) begin
      if (!full || pop) begin
        push_ok = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
  end

  // Load data is combinational so the pipeline can capture it into MEM/WB
  // on the same edge as a normal RAM read. Anything other than a status
  // load returns zero, including loads from the write-only data register.
  always_comb begin
    read_data = 32'b0;
    if (read_enable && status_sel) begin
      read_data = {28'b0, overflow, tx_busy, empty, full};
    end
  end

  // FIFO storage. The array is not reset: the pointers and count define
  // which entries are meaningful, so stale contents are never observed.
  // When a push and a pop hit the same slot in a full FIFO, the pop reads
  // the old byte because both sides use the pre-edge value.
  always_ff @(posedge clk) begin
    if (reset && push_ok) begin
      fifo_mem[wr_ptr] <= write_data[7:0];
    end
  end

  // FIFO bookkeeping. Pointers wrap naturally because the depth is a power
  // of two. A simultaneous push and pop leaves the count alone. The
  // overflow flag is sticky; a drop in the same cycle as a clear wins so
  // software never loses evidence of a lost byte.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_req) begin
        overflow <= 1'b0;
      end
    end
  end

  // Serializer state machine. tx is registered from the current state, so
  // the line follows the state with one cycle of latency and never
  // glitches. Each bit period is BAUD_DIV cycles; data goes out LSB first
  // by shifting right at the end of every data bit. A reset mid-frame
  // drops everything and forces the line high on the next edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
      tx        <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift_reg <= fifo_mem[rd_ptr];
            baud_cnt  <= '0;
            state     <= START;
          end
        end

        START: begin
          tx <= 1'b0;
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        DATA: begin
          tx <= shift_reg[0];
          if (baud_last) begin
            baud_cnt  <= '0;
            shift_reg <= {1'b0, shift_reg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        STOP: begin
          tx <= 1'b1;
          if (baud_last) begin
            baud_cnt <= '0;
            if (pop) begin
              shift_reg <= fifo_mem[rd_ptr];
              state     <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_port
//
// Drives uart_tx_port with BAUD_DIV=4 and FIFO_DEPTH=8 through a linear
// sequence of directed steps with randomized bytes and bus traffic. A
// reference model tracks every accepted byte together with the cycle it is
// pushed and the cycle the transmitter picks it up, and derives the line
// level, busy flag and status word from those timestamps.
// ---------------------------------------------------------------------------
module tb_uart_tx_port;

  localparam int          BD          = 4;
  localparam int          DEPTH       = 8;
  localparam int          FRAME       = 10 * BD;
  localparam logic [31:0] DATA_ADDR   = 32'h1001_0024;
  localparam logic [31:0] STATUS_ADDR = 32'h1001_0028;

  logic        clk;
  logic        reset;
  logic        write_enable;
  logic        read_enable;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        hit;
  logic [31:0] read_data;
  logic        tx;
  logic        tx_busy;

  int tests_run;
  int tests_failed;

  // Model state: one entry per accepted byte, stamped with the edge it was
  // pushed on and the edge the transmitter pops it.
  logic [7:0] q_data [$];
  int         q_push [$];
  int         q_pop  [$];
  int         now;
  int         last_pop;
  logic       ovf;
  bit         model_ok;

  logic [31:0] last_rd;
  logic        last_hit;

  uart_tx_port #(
    .BAUD_DIV   (BD),
    .FIFO_DEPTH (DEPTH),
    .DATA_ADDR  (DATA_ADDR),
    .STATUS_ADDR(STATUS_ADDR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .write_enable(write_enable),
    .read_enable (read_enable),
    .address     (address),
    .write_data  (write_data),
    .hit         (hit),
    .read_data   (read_data),
    .tx          (tx),
    .tx_busy     (tx_busy)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of bytes held in the FIFO just after edge t.
  function automatic int count_at(input int t);
    int n;
    n = 0;
    foreach (q_push[i]) begin
      if (q_push[i] <= t && q_pop[i] > t) n++;
    end
    return n;
  endfunction

  function automatic bit pop_at(input int e);
    foreach (q_pop[i]) begin
      if (q_pop[i] == e) return 1'b1;
    end
    return 1'b0;
  endfunction

  // A frame popped at edge p occupies the line from edge p+1 for FRAME
  // cycles: one start bit, eight data bits LSB first, one stop bit.
  function automatic logic exp_tx(input int t);
    int         k;
    logic [7:0] d;
    foreach (q_pop[i]) begin
      if (t >= q_pop[i] + 1 && t < q_pop[i] + 1 + FRAME) begin
        k = (t - q_pop[i] - 1) / BD;
        d = q_data[i];
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return d[k-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic exp_busy(input int t);
    foreach (q_pop[i]) begin
      if (t >= q_pop[i] && t < q_pop[i] + FRAME) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return DATA_ADDR;
      1:       return STATUS_ADDR;
      2:       return 32'h1001_0000;
      default: return $urandom;
    endcase
  endfunction

  // One comparison: counts it and reports a mismatch through an assertion.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drives one clock cycle of bus activity. The combinational outputs are
  // checked against the model before the edge, the model is advanced to
  // the edge, and the registered outputs are checked half a cycle later.
  task automatic applyStimulus(input logic rst_v, input logic we_v,
                               input logic re_v, input logic [31:0] addr_v,
                               input logic [31:0] wd_v);
    int          e;
    int          cnt;
    int          p;
    bit          dropped;
    logic        ovf_next;
    bit          ok_next;
    logic [31:0] exp_rd;
    reset        = rst_v;
    write_enable = we_v;
    read_enable  = re_v;
    address      = addr_v;
    write_data   = wd_v;
    #1;
    last_rd  = read_data;
    last_hit = hit;
    if (model_ok) begin
      cnt    = count_at(now);
      exp_rd = 32'b0;
      if (re_v && addr_v == STATUS_ADDR) begin
        exp_rd = {28'b0, ovf, exp_busy(now), cnt == 0, cnt == DEPTH};
      end
      checkOutput("hit", {31'b0, hit},
                  {31'b0, (addr_v == DATA_ADDR || addr_v == STATUS_ADDR)});
      checkOutput("read_data", read_data, exp_rd);
    end
    e        = now + 1;
    ovf_next = ovf;
    ok_next  = model_ok;
    dropped  = 1'b0;
    if (!rst_v) begin
      q_data.delete();
      q_push.delete();
      q_pop.delete();
      last_pop = -1000;
      ovf_next = 1'b0;
      ok_next  = 1'b1;
    end else if (model_ok) begin
      if (we_v && addr_v == DATA_ADDR) begin
        if (count_at(e - 1) < DEPTH || pop_at(e)) begin
          p = (e + 1 > last_pop + FRAME) ? e + 1 : last_pop + FRAME;
          q_data.push_back(wd_v[7:0]);
          q_push.push_back(e);
          q_pop.push_back(p);
          last_pop = p;
        end else begin
          dropped  = 1'b1;
          ovf_next = 1'b1;
        end
      end
      if (we_v && addr_v == STATUS_ADDR && wd_v[3] && !dropped) begin
        ovf_next = 1'b0;
      end
    end
    @(posedge clk);
    now++;
    ovf      = ovf_next;
    model_ok = ok_next;
    @(negedge clk);
    if (model_ok) begin
      checkOutput("tx", {31'b0, tx}, {31'b0, exp_tx(now)});
      checkOutput("tx_busy", {31'b0, tx_busy}, {31'b0, exp_busy(now)});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)), pick_addr(), $urandom);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    logic [31:0] rnd;
    rnd = $urandom;
    applyStimulus(1'b1, 1'b1, 1'($urandom_range(0, 1)), DATA_ADDR, {rnd[31:8], b});
  endtask

  task automatic read_status();
    applyStimulus(1'b1, 1'b0, 1'b1, STATUS_ADDR, 32'h0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    now          = 0;
    last_pop     = -1000;
    ovf          = 1'b0;
    model_ok     = 1'b0;
    reset        = 1'b0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    address      = 32'h0;
    write_data   = 32'h0;

    // Step 1: reset for two cycles, then the status shows only "empty".
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    read_status();
    checkOutput("reset_status", last_rd, 32'h2);

    // Step 2: a single 0x55 frame, then a random byte, each drained fully.
    push_byte(8'h55);
    idle(45);
    push_byte(8'($urandom));
    idle(45);
    read_status();
    checkOutput("idle_status", last_rd, 32'h2);

    // Step 3: ten back-to-back stores; the first pops at once, the next
    // eight fill the FIFO and the tenth is dropped.
    for (int i = 0; i < 10; i++) push_byte(8'($urandom));
    read_status();
    checkOutput("overflow_status", last_rd, 32'hD);
    applyStimulus(1'b1, 1'b1, 1'b0, STATUS_ADDR, 32'h8);
    read_status();
    checkOutput("cleared_status", last_rd, 32'h5);
    idle(420);

    // Step 4: two queued bytes chain with no idle gap between frames.
    push_byte(8'hA5);
    push_byte(8'h3C);
    idle(90);
    push_byte(8'($urandom));
    push_byte(8'($urandom));
    idle(90);

    // Step 5: reset in the middle of the 0xFF data bits with bytes queued.
    push_byte(8'hFF);
    for (int i = 0; i < 3; i++) push_byte(8'($urandom));
    idle(12);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    read_status();
    checkOutput("abort_status", last_rd, 32'h2);
    idle(60);

    // Step 6: an unmapped load, then a push while full that lands on the
    // same edge as the stop-bit pop and must be accepted.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h1001_0000, 32'h0);
    checkOutput("unmapped_hit", {31'b0, last_hit}, 32'h0);
    checkOutput("unmapped_data", last_rd, 32'h0);
    for (int i = 0; i < 9; i++) push_byte(8'($urandom));
    idle(32);
    push_byte(8'($urandom));
    read_status();
    checkOutput("full_pop_push_status", last_rd, 32'h5);
    idle(400);

    // Step 7: random mix of pushes, overflow clears and reads.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: push_byte(8'($urandom));
        3:       applyStimulus(1'b1, 1'b1, 1'($urandom_range(0, 1)), STATUS_ADDR, $urandom);
        default: idle(1);
      endcase
    end
    idle(450);
    read_status();
    checkOutput("final_empty", {30'b0, last_rd[1:0]}, 32'h2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
